// File: rtl/sparkbox_gpu_pkg.sv
// Shared GPU command-path types: render/defer state encoding, default bus widths
// and the default-width packed write-queue entry.
package sparkbox_gpu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int DEPTH_DEF  = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RENDER = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/cmd_write_defer_queue_if.sv
// Command, read-request and write-port handshakes of the write defer queue.
// The slave modport is the queue itself; master is its surroundings.
interface cmd_write_defer_queue_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_is_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport slave (
        input  cmd_valid, cmd_is_write, cmd_addr, cmd_wdata, rd_ready, wr_ready,
        output cmd_ready, rd_valid, rd_addr, wr_valid, wr_addr, wr_data
    );

    modport master (
        output cmd_valid, cmd_is_write, cmd_addr, cmd_wdata, rd_ready, wr_ready,
        input  cmd_ready, rd_valid, rd_addr, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/cmd_sync_fifo.sv
// Parameterised synchronous FIFO with full/empty/count; head word is visible on
// o_rdata whenever the FIFO is non-empty. Push is honoured when full if a pop coincides.
module cmd_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers alone define which words are valid.
    always_ff @(posedge clk_in) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/cmd_write_defer_queue.sv
// Defers command writes issued during a frame render and retires them in order afterwards;
// reads bypass through a one-entry stage. Optional macro DEFER_STATS_EN adds occupancy stats.
module cmd_write_defer_queue
    import sparkbox_gpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    cmd_write_defer_queue_if.slave bus,
    input  logic                   render_active,
    output logic                   render_ok,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   order_err
`ifdef DEFER_STATS_EN
    ,
    output logic [$clog2(DEPTH):0] max_count,
    output logic [15:0]            stall_cycles
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_render_ok;
    logic                r_order_err;
    logic                r_rd_valid;
    logic [ADDR_W-1:0]   r_rd_addr;

    entry_t              w_push_entry;
    entry_t              w_head;
    logic [$bits(entry_t)-1:0] w_head_bits;
    logic                w_full;
    logic                w_empty;
    logic                w_empty_next;
    logic [CNT_W-1:0]    w_count;
    logic                w_push;
    logic                w_pop;
    logic                w_wr_valid;
    logic                w_rd_slot_ok;
    logic                w_cmd_ready;
    logic                w_rd_accept;

    assign w_push_entry = '{addr: bus.cmd_addr, data: bus.cmd_wdata};
    assign w_head       = entry_t'(w_head_bits);

    cmd_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_wdata  (w_push_entry),
        .o_rdata  (w_head_bits),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // Queue is empty after this edge if nothing is pushed and it is (or becomes) drained.
    assign w_empty_next = !w_push && (w_empty || (w_count == CNT_W'(1) && w_pop));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (render_active) w_state_next = RENDER;
            RENDER:  if (!render_active) w_state_next = w_empty ? IDLE : DRAIN;
            DRAIN: begin
                if (render_active)     w_state_next = RENDER;
                else if (w_empty_next) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Writes are gated off combinationally by render_active so none escapes on its rising cycle.
    always_comb begin
        w_wr_valid   = !w_empty && (r_state != RENDER) && !render_active;
        w_pop        = w_wr_valid && bus.wr_ready;
        w_rd_slot_ok = !r_rd_valid && ((r_state == RENDER) || w_empty);
        w_cmd_ready  = bus.cmd_valid && !reset_in &&
                       (bus.cmd_is_write ? (!w_full || w_pop) : w_rd_slot_ok);
        w_push       = w_cmd_ready && bus.cmd_is_write;
        w_rd_accept  = w_cmd_ready && !bus.cmd_is_write;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_render_ok <= 1'b1;
            r_order_err <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= '0;
        end else begin
            r_render_ok <= (w_state_next == IDLE) && w_empty_next;
            if (r_state == DRAIN && render_active) r_order_err <= 1'b1;
            if (w_rd_accept) begin
                r_rd_valid <= 1'b1;
                r_rd_addr  <= bus.cmd_addr;
            end else if (bus.rd_ready) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.wr_valid  = w_wr_valid;
    assign bus.wr_addr   = w_wr_valid ? w_head.addr : '0;
    assign bus.wr_data   = w_wr_valid ? w_head.data : '0;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_addr   = r_rd_addr;
    assign render_ok     = r_render_ok;
    assign queue_count   = w_count;
    assign order_err     = r_order_err;

`ifdef DEFER_STATS_EN
    logic [CNT_W-1:0] r_max_count;
    logic [15:0]      r_stall_cycles;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_max_count    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_count > r_max_count) r_max_count <= w_count;
            if (bus.cmd_valid && bus.cmd_is_write && w_full && r_stall_cycles != 16'hFFFF)
                r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign max_count    = r_max_count;
    assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_cmd_write_defer_queue.sv
// Directed bench for cmd_write_defer_queue: deferral, full queue, read-after-write,
// render-rise collision, order error and reset; expected values are hand-derived.
module tb_cmd_write_defer_queue;
    import sparkbox_gpu_pkg::*;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       render_active;
    logic       render_ok;
    logic [6:0] queue_count;
    logic       order_err;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_hs  = 0;
    wr_entry_t  exp_e;

    always #5 clk_in = ~clk_in;

    cmd_write_defer_queue_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef DEFER_STATS_EN
    logic [6:0]  max_count;
    logic [15:0] stall_cycles;
`endif

    cmd_write_defer_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(64)) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .bus           (bus),
        .render_active (render_active),
        .render_ok     (render_ok),
        .queue_count   (queue_count),
        .order_err     (order_err)
`ifdef DEFER_STATS_EN
        ,
        .max_count     (max_count),
        .stall_cycles  (stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_cmd(input logic is_wr, input logic [15:0] a, input logic [15:0] d);
        bus.cmd_valid    = 1'b1;
        bus.cmd_is_write = is_wr;
        bus.cmd_addr     = a;
        bus.cmd_wdata    = d;
        #1;
    endtask

    task automatic idle_cmd();
        bus.cmd_valid    = 1'b0;
        bus.cmd_is_write = 1'b0;
        bus.cmd_addr     = '0;
        bus.cmd_wdata    = '0;
        #1;
    endtask

    initial begin
        reset_in      = 1'b1;
        render_active = 1'b0;
        bus.rd_ready  = 1'b0;
        bus.wr_ready  = 1'b0;
        idle_cmd();
        tick();
        tick();
        chk("rst_render_ok", render_ok, 1);
        chk("rst_count", queue_count, 0);
        chk("rst_wr_valid", bus.wr_valid, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_order_err", order_err, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        reset_in = 1'b0;
        tick();
        chk("post_rst_render_ok", render_ok, 1);

        // Palette write deferral
        bus.wr_ready = 1'b1;
        drive_cmd(1'b1, 16'h0305, 16'hF800);
        chk("pal_red_ready", bus.cmd_ready, 1);
        tick();
        idle_cmd();
        chk("pal_red_wr_valid", bus.wr_valid, 1);
        chk("pal_red_wr_data", bus.wr_data, 16'hF800);
        chk("pal_red_render_ok", render_ok, 0);
        tick();
        chk("pal_red_count", queue_count, 0);
        chk("pal_red_done_ok", render_ok, 1);
        render_active = 1'b1;
        tick();
        chk("pal_render_ok_low", render_ok, 0);
        drive_cmd(1'b1, 16'h0305, 16'h8410);
        chk("pal_gray_ready", bus.cmd_ready, 1);
        tick();
        chk("pal_gray_count", queue_count, 1);
        chk("pal_gray_held", bus.wr_valid, 0);
        drive_cmd(1'b0, 16'h0305, 16'h0000);
        chk("pal_rd_ready", bus.cmd_ready, 1);
        tick();
        idle_cmd();
        chk("pal_rd_valid", bus.rd_valid, 1);
        chk("pal_rd_addr", bus.rd_addr, 16'h0305);
        chk("pal_rd_no_wr", bus.wr_valid, 0);
        tick();
        chk("pal_rd_stable", bus.rd_valid, 1);
        chk("pal_rd_addr_stable", bus.rd_addr, 16'h0305);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("pal_rd_retired", bus.rd_valid, 0);
        render_active = 1'b0;
        #1;
        chk("pal_fall_same_cycle", bus.wr_valid, 0);
        tick();
        chk("pal_drain_wr_valid", bus.wr_valid, 1);
        chk("pal_drain_wr_addr", bus.wr_addr, 16'h0305);
        chk("pal_drain_wr_data", bus.wr_data, 16'h8410);
        chk("pal_drain_render_ok", render_ok, 0);
        tick();
        chk("pal_done_count", queue_count, 0);
        chk("pal_done_render_ok", render_ok, 1);
        chk("pal_done_wr_valid", bus.wr_valid, 0);

        // Render rise collision
        bus.wr_ready = 1'b0;
        drive_cmd(1'b1, 16'h0020, 16'hAAAA);
        tick();
        idle_cmd();
        render_active = 1'b1;
        #1;
        chk("coll_wr_valid", bus.wr_valid, 0);
        chk("coll_count", queue_count, 1);
        tick();
        chk("coll_render_wr_valid", bus.wr_valid, 0);
        chk("coll_render_count", queue_count, 1);
        render_active = 1'b0;
        tick();
        chk("coll_drain_wr_valid", bus.wr_valid, 1);
        chk("coll_drain_wr_addr", bus.wr_addr, 16'h0020);
        bus.wr_ready = 1'b1;
        tick();
        bus.wr_ready = 1'b0;
        chk("coll_done_count", queue_count, 0);
        chk("coll_done_render_ok", render_ok, 1);

        // IDLE read-after-write
        drive_cmd(1'b1, 16'h0010, 16'h1234);
        tick();
        drive_cmd(1'b0, 16'h0010, 16'h0000);
        chk("raw_wr_valid", bus.wr_valid, 1);
        chk("raw_rd_blocked", bus.cmd_ready, 0);
        tick();
        chk("raw_rd_blocked2", bus.cmd_ready, 0);
        chk("raw_no_rd_valid", bus.rd_valid, 0);
        bus.wr_ready = 1'b1;
        #1;
        chk("raw_rd_blocked_pop", bus.cmd_ready, 0);
        tick();
        bus.wr_ready = 1'b0;
        #1;
        chk("raw_count_zero", queue_count, 0);
        chk("raw_rd_ready", bus.cmd_ready, 1);
        chk("raw_rd_not_yet", bus.rd_valid, 0);
        tick();
        idle_cmd();
        chk("raw_rd_valid", bus.rd_valid, 1);
        chk("raw_rd_addr", bus.rd_addr, 16'h0010);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("raw_rd_retired", bus.rd_valid, 0);

        // Full queue
        render_active = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) begin
            drive_cmd(1'b1, 16'h1000 + 16'(i), 16'h5000 + 16'(i));
            chk($sformatf("full_push_ready_%0d", i), bus.cmd_ready, 1);
            tick();
        end
        drive_cmd(1'b1, 16'h1040, 16'h5040);
        chk("full_65th_ready", bus.cmd_ready, 0);
        chk("full_count", queue_count, 64);
        tick();
        idle_cmd();
        chk("full_count_hold", queue_count, 64);
        render_active = 1'b0;
        bus.wr_ready  = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) begin
            exp_e.addr = 16'h1000 + 16'(i);
            exp_e.data = 16'h5000 + 16'(i);
            chk($sformatf("full_drain_valid_%0d", i), bus.wr_valid, 1);
            chk($sformatf("full_drain_entry_%0d", i), {bus.wr_addr, bus.wr_data}, exp_e);
            if (bus.wr_valid && bus.wr_ready) n_hs++;
            tick();
        end
        bus.wr_ready = 1'b0;
        chk("full_handshakes", n_hs, 64);
        chk("full_done_count", queue_count, 0);
        chk("full_done_render_ok", render_ok, 1);
        chk("full_done_wr_valid", bus.wr_valid, 0);

        // Order error and reset
        render_active = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_cmd(1'b1, 16'h2000 + 16'(i), 16'h0100 + 16'(i));
            tick();
        end
        idle_cmd();
        render_active = 1'b0;
        tick();
        chk("oe_drain_count", queue_count, 3);
        chk("oe_drain_wr_valid", bus.wr_valid, 1);
        chk("oe_drain_wr_addr", bus.wr_addr, 16'h2000);
        chk("oe_before", order_err, 0);
        render_active = 1'b1;
        #1;
        chk("oe_rise_wr_valid", bus.wr_valid, 0);
        tick();
        chk("oe_set", order_err, 1);
        chk("oe_count", queue_count, 3);
        chk("oe_render_ok", render_ok, 0);
        render_active = 1'b0;
        #1;
        chk("oe_state_render", bus.wr_valid, 0);
        tick();
        chk("oe_sticky", order_err, 1);
        chk("oe_redrain_wr_valid", bus.wr_valid, 1);
        reset_in = 1'b1;
        tick();
        chk("oe_rst_count", queue_count, 0);
        chk("oe_rst_render_ok", render_ok, 1);
        chk("oe_rst_order_err", order_err, 0);
        chk("oe_rst_wr_valid", bus.wr_valid, 0);
        reset_in = 1'b0;
        tick();
        chk("oe_post_count", queue_count, 0);
        chk("oe_post_render_ok", render_ok, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
